// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding and coin values for the vend datapath
package vend_pkg;

  // Dispenser sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ITEM   = 3'd1,
    ST_PICK   = 3'd2,
    ST_EJECT  = 3'd3,
    ST_GAP    = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  // Which ejector the current EJECT interval drives
  typedef enum logic [1:0] {
    COIN_NONE   = 2'd0,
    COIN_NICKEL = 2'd1,
    COIN_DIME   = 2'd2
  } coin_e;

  // Coin values in nickel units, sized to the internal remaining-change register
  localparam logic [4:0] NICKEL_UNITS = 5'd1;
  localparam logic [4:0] DIME_UNITS   = 5'd2;

endpackage

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable down-counter with an expired flag, shared by pulse and gap intervals
module pulse_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A load wins over counting; the count parks at zero once it gets there
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loading N-1 makes the owning state last exactly N cycles
  assign expired = (cnt_q == '0);

endmodule

// File: rtl/coin_dispenser.sv
// rtl/coin_dispenser.sv - item solenoid plus nickel/dime change payout with tube inventory
module coin_dispenser
  import vend_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 6,
  parameter int NICKEL_INIT  = 10,
  parameter int DIME_INIT    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             vend,
  input  logic [3:0]       change,
  input  logic             refill_n,
  input  logic             refill_d,
  output logic             item_sol,
  output logic             nickel_sol,
  output logic             dime_sol,
  output logic             busy,
  output logic             done,
  output logic             short_chg,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt
);

  localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  coin_e            coin_q, coin_d;
  logic [4:0]       rem_q, rem_d;
  logic             short_q, short_d;
  logic             item_sol_q, item_sol_d;
  logic             nickel_sol_q, nickel_sol_d;
  logic             dime_sol_q, dime_sol_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] nickel_cnt_q, nickel_cnt_d;
  logic [CNT_W-1:0] dime_cnt_q, dime_cnt_d;
  logic             dec_n, dec_d;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_exp;

  pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Next-state, coin selection and timer control; dimes are preferred while two units remain
  always_comb begin
    state_d  = state_q;
    coin_d   = coin_q;
    rem_d    = rem_q;
    short_d  = short_q;
    dec_n    = 1'b0;
    dec_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = PULSE_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          rem_d    = {1'b0, change};
          short_d  = 1'b0;
          tmr_load = vend;
          state_d  = vend ? ST_ITEM : ST_PICK;
        end
      end
      ST_ITEM: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end
      end
      ST_PICK: begin
        if (rem_q == '0) begin
          state_d = ST_FINISH;
        end else if (rem_q >= DIME_UNITS && dime_cnt_q != '0) begin
          coin_d   = COIN_DIME;
          rem_d    = rem_q - DIME_UNITS;
          dec_d    = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_EJECT;
        end else if (nickel_cnt_q != '0) begin
          coin_d   = COIN_NICKEL;
          rem_d    = rem_q - NICKEL_UNITS;
          dec_n    = 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_EJECT;
        end else begin
          short_d = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_EJECT: begin
        if (tmr_exp) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_exp) begin
          state_d = ST_PICK;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it
    item_sol_d   = (state_d == ST_ITEM);
    nickel_sol_d = (state_d == ST_EJECT) && (coin_d == COIN_NICKEL);
    dime_sol_d   = (state_d == ST_EJECT) && (coin_d == COIN_DIME);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_FINISH);
  end

  // Tube inventory: saturating refill, a refill that coincides with a payout cancels it
  always_comb begin
    nickel_cnt_d = nickel_cnt_q;
    if (refill_n && !dec_n) begin
      if (nickel_cnt_q != CNT_MAX) begin
        nickel_cnt_d = nickel_cnt_q + 1'b1;
      end
    end else if (dec_n && !refill_n) begin
      nickel_cnt_d = nickel_cnt_q - 1'b1;
    end

    dime_cnt_d = dime_cnt_q;
    if (refill_d && !dec_d) begin
      if (dime_cnt_q != CNT_MAX) begin
        dime_cnt_d = dime_cnt_q + 1'b1;
      end
    end else if (dec_d && !refill_d) begin
      dime_cnt_d = dime_cnt_q - 1'b1;
    end
  end

  // All sequencing state and registered outputs; reset drops every solenoid at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      coin_q       <= COIN_NONE;
      rem_q        <= '0;
      short_q      <= 1'b0;
      item_sol_q   <= 1'b0;
      nickel_sol_q <= 1'b0;
      dime_sol_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      nickel_cnt_q <= CNT_W'(NICKEL_INIT);
      dime_cnt_q   <= CNT_W'(DIME_INIT);
    end else begin
      state_q      <= state_d;
      coin_q       <= coin_d;
      rem_q        <= rem_d;
      short_q      <= short_d;
      item_sol_q   <= item_sol_d;
      nickel_sol_q <= nickel_sol_d;
      dime_sol_q   <= dime_sol_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      nickel_cnt_q <= nickel_cnt_d;
      dime_cnt_q   <= dime_cnt_d;
    end
  end

  assign item_sol   = item_sol_q;
  assign nickel_sol = nickel_sol_q;
  assign dime_sol   = dime_sol_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short_chg  = short_q;
  assign nickel_cnt = nickel_cnt_q;
  assign dime_cnt   = dime_cnt_q;

endmodule

// File: tb/tb_coin_dispenser.sv
// tb/tb_coin_dispenser.sv - self-checking bench for coin_dispenser across three inventory configurations
module tb_coin_dispenser;

  localparam int PULSE = 4;
  localparam int GAP   = 2;
  localparam int CMAX  = 63;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req [3];
  logic       vend [3];
  logic [3:0] change [3];
  logic       refill_n [3];
  logic       refill_d [3];
  logic       item_w [3];
  logic       nsol_w [3];
  logic       dsol_w [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       short_w [3];
  logic [5:0] ncnt_w [3];
  logic [5:0] dcnt_w [3];

  int checks;
  int errors;

  // Expected per-cycle outputs of one transaction, generated up front from the payout rules
  typedef struct packed {
    logic item;
    logic nsol;
    logic dsol;
    logic busy;
    logic done;
    logic set_sc;
    logic dec_n;
    logic dec_d;
  } ent_t;

  ent_t q[$];
  int   act;
  int   cn [3];
  int   cd [3];
  logic sc [3];

  coin_dispenser #(.NICKEL_INIT(10), .DIME_INIT(10)) u0 (
    .clk(clk), .rst(rst_n), .req(req[0]), .vend(vend[0]), .change(change[0]),
    .refill_n(refill_n[0]), .refill_d(refill_d[0]), .item_sol(item_w[0]),
    .nickel_sol(nsol_w[0]), .dime_sol(dsol_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .short_chg(short_w[0]), .nickel_cnt(ncnt_w[0]), .dime_cnt(dcnt_w[0]));

  coin_dispenser #(.NICKEL_INIT(10), .DIME_INIT(0)) u1 (
    .clk(clk), .rst(rst_n), .req(req[1]), .vend(vend[1]), .change(change[1]),
    .refill_n(refill_n[1]), .refill_d(refill_d[1]), .item_sol(item_w[1]),
    .nickel_sol(nsol_w[1]), .dime_sol(dsol_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .short_chg(short_w[1]), .nickel_cnt(ncnt_w[1]), .dime_cnt(dcnt_w[1]));

  coin_dispenser #(.NICKEL_INIT(0), .DIME_INIT(1)) u2 (
    .clk(clk), .rst(rst_n), .req(req[2]), .vend(vend[2]), .change(change[2]),
    .refill_n(refill_n[2]), .refill_d(refill_d[2]), .item_sol(item_w[2]),
    .nickel_sol(nsol_w[2]), .dime_sol(dsol_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .short_chg(short_w[2]), .nickel_cnt(ncnt_w[2]), .dime_cnt(dcnt_w[2]));

  always #5 clk = ~clk;

  function automatic int ninit(input int i);
    return (i == 2) ? 0 : 10;
  endfunction

  function automatic int dinit(input int i);
    return (i == 0) ? 10 : ((i == 1) ? 0 : 1);
  endfunction

  function automatic ent_t mk(input logic it, input logic ns, input logic ds, input logic dn,
                              input logic s, input logic decn, input logic decd);
    ent_t e;
    e.item   = it;
    e.nsol   = ns;
    e.dsol   = ds;
    e.busy   = 1'b1;
    e.done   = dn;
    e.set_sc = s;
    e.dec_n  = decn;
    e.dec_d  = decd;
    return e;
  endfunction

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, a, e);
    end
  endtask

  // Whole-transaction schedule: optional item pulse, then greedy dime-first payout
  task automatic build(input int i, input logic v, input int c);
    int rem;
    int n;
    int d;
    bit fin;
    rem = c;
    n   = cn[i];
    d   = cd[i];
    fin = 1'b0;
    if (v) begin
      repeat (PULSE) q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      repeat (GAP) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    end
    while (!fin) begin
      if (rem == 0) begin
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        fin = 1'b1;
      end else if (rem >= 2 && d > 0) begin
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
        repeat (PULSE) q.push_back(mk(0, 0, 1, 0, 0, 0, 0));
        repeat (GAP) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        rem = rem - 2;
        d   = d - 1;
      end else if (n > 0) begin
        q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        repeat (PULSE) q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
        repeat (GAP) q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        rem = rem - 1;
        n   = n - 1;
      end else begin
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 1, 0, 0));
        fin = 1'b1;
      end
    end
  endtask

  // One clock: compare every instance against the model mid-cycle, then advance the model
  task automatic tick();
    ent_t e;
    bit   was_idle;
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 3; i++) begin
        cn[i] = ninit(i);
        cd[i] = dinit(i);
        sc[i] = 1'b0;
      end
    end
    was_idle = (q.size() == 0);
    for (int i = 0; i < 3; i++) begin
      e = '0;
      if (!was_idle && i == act) e = q[0];
      if (e.set_sc) sc[i] = 1'b1;
      chk($sformatf("u%0d_item_sol", i), int'(item_w[i]), int'(e.item));
      chk($sformatf("u%0d_nickel_sol", i), int'(nsol_w[i]), int'(e.nsol));
      chk($sformatf("u%0d_dime_sol", i), int'(dsol_w[i]), int'(e.dsol));
      chk($sformatf("u%0d_busy", i), int'(busy_w[i]), int'(e.busy));
      chk($sformatf("u%0d_done", i), int'(done_w[i]), int'(e.done));
      chk($sformatf("u%0d_short_chg", i), int'(short_w[i]), int'(sc[i]));
      chk($sformatf("u%0d_nickel_cnt", i), int'(ncnt_w[i]), cn[i]);
      chk($sformatf("u%0d_dime_cnt", i), int'(dcnt_w[i]), cd[i]);
    end
    if (rst_n) begin
      if (!was_idle) begin
        e = q.pop_front();
        if (e.dec_n) cn[act] = cn[act] - 1;
        if (e.dec_d) cd[act] = cd[act] - 1;
      end
      for (int i = 0; i < 3; i++) begin
        if (refill_n[i] && cn[i] < CMAX) cn[i] = cn[i] + 1;
        if (refill_d[i] && cd[i] < CMAX) cd[i] = cd[i] + 1;
      end
      if (was_idle) begin
        for (int i = 0; i < 3; i++) begin
          if (req[i]) begin
            act   = i;
            sc[i] = 1'b0;
            build(i, vend[i], int'(change[i]));
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Issue one request and observe the instance for ncyc cycles; 'again' re-asserts req while busy
  task automatic run_txn(input int i, input logic v, input logic [3:0] c, input int ncyc,
                         input int again, output int n_item, output int n_nick,
                         output int n_dime, output int n_done, output int f_nick,
                         output int f_dime, output int c_done);
    n_item = 0;
    n_nick = 0;
    n_dime = 0;
    n_done = 0;
    f_nick = -1;
    f_dime = -1;
    c_done = -1;
    req[i]    = 1'b1;
    vend[i]   = v;
    change[i] = c;
    tick();
    req[i] = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      if (item_w[i]) n_item++;
      if (nsol_w[i]) begin
        n_nick++;
        if (f_nick < 0) f_nick = k;
      end
      if (dsol_w[i]) begin
        n_dime++;
        if (f_dime < 0) f_dime = k;
      end
      if (done_w[i]) begin
        n_done++;
        c_done = k;
      end
      req[i] = (k == again);
      tick();
    end
    req[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int ni, nn, nd, ndn, fn, fd, cdn;
    checks = 0;
    errors = 0;
    act    = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i]      = 1'b0;
      vend[i]     = 1'b0;
      change[i]   = 4'd0;
      refill_n[i] = 1'b0;
      refill_d[i] = 1'b0;
    end
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_u0_dime_cnt", int'(dcnt_w[0]), 10);
    chk("rst_u2_nickel_cnt", int'(ncnt_w[2]), 0);
    chk("rst_u0_busy", int'(busy_w[0]), 0);

    // change=2, no item: one dime in cycles 2-5, done in cycle 9
    run_txn(0, 1'b0, 4'd2, 11, 0, ni, nn, nd, ndn, fn, fd, cdn);
    chk("t1_first_dime", fd, 2);
    chk("t1_dime_cycles", nd, 4);
    chk("t1_nickel_cycles", nn, 0);
    chk("t1_done_cycle", cdn, 9);
    chk("t1_done_count", ndn, 1);
    chk("t1_dime_cnt", int'(dcnt_w[0]), 9);
    chk("t1_short", int'(short_w[0]), 0);

    // item then change=3: item, dime, nickel
    do_reset();
    run_txn(0, 1'b1, 4'd3, 25, 0, ni, nn, nd, ndn, fn, fd, cdn);
    chk("t2_item_cycles", ni, 4);
    chk("t2_first_dime", fd, 8);
    chk("t2_first_nickel", fn, 15);
    chk("t2_done_cycle", cdn, 22);
    chk("t2_done_count", ndn, 1);
    chk("t2_nickel_cnt", int'(ncnt_w[0]), 9);
    chk("t2_dime_cnt", int'(dcnt_w[0]), 9);

    // no dimes: change=4 paid in four nickels
    run_txn(1, 1'b0, 4'd4, 32, 0, ni, nn, nd, ndn, fn, fd, cdn);
    chk("t3_nickel_cycles", nn, 16);
    chk("t3_dime_cycles", nd, 0);
    chk("t3_done_cycle", cdn, 30);
    chk("t3_nickel_cnt", int'(ncnt_w[1]), 6);
    chk("t3_short", int'(short_w[1]), 0);

    // one dime, no nickels: change=3 comes up short
    run_txn(2, 1'b0, 4'd3, 12, 0, ni, nn, nd, ndn, fn, fd, cdn);
    chk("t4_dime_cycles", nd, 4);
    chk("t4_nickel_cycles", nn, 0);
    chk("t4_done_cycle", cdn, 9);
    chk("t4_short_latched", int'(short_w[2]), 1);
    chk("t4_dime_cnt", int'(dcnt_w[2]), 0);

    // change=0: PICK then FINISH, and the next accepted req clears short_chg
    run_txn(2, 1'b0, 4'd0, 4, 0, ni, nn, nd, ndn, fn, fd, cdn);
    chk("t4b_done_cycle", cdn, 2);
    chk("t4b_short_cleared", int'(short_w[2]), 0);

    // refill_d during the dime pick cycle cancels the decrement
    req[0]    = 1'b1;
    vend[0]   = 1'b0;
    change[0] = 4'd2;
    tick();
    req[0]      = 1'b0;
    refill_d[0] = 1'b1;
    chk("t5_dime_cnt_pick", int'(dcnt_w[0]), 9);
    tick();
    refill_d[0] = 1'b0;
    chk("t5_dime_cnt_eject", int'(dcnt_w[0]), 9);
    chk("t5_dime_sol", int'(dsol_w[0]), 1);
    repeat (10) tick();
    chk("t5_busy_end", int'(busy_w[0]), 0);

    // saturation at 63
    refill_d[1] = 1'b1;
    repeat (70) tick();
    refill_d[1] = 1'b0;
    chk("t5_dime_sat", int'(dcnt_w[1]), 63);

    // asynchronous reset in the middle of a nickel pulse
    req[0]    = 1'b1;
    change[0] = 4'd1;
    tick();
    req[0] = 1'b0;
    tick();
    tick();
    chk("t6_nickel_before", int'(nsol_w[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_nickel_drop", int'(nsol_w[0]), 0);
    chk("t6_busy_drop", int'(busy_w[0]), 0);
    chk("t6_nickel_init", int'(ncnt_w[0]), 10);
    chk("t6_dime_init", int'(dcnt_w[0]), 10);
    tick();
    rst_n = 1'b1;

    // a second req while busy is ignored
    run_txn(0, 1'b0, 4'd2, 14, 3, ni, nn, nd, ndn, fn, fd, cdn);
    chk("t7_done_count", ndn, 1);
    chk("t7_done_cycle", cdn, 9);
    chk("t7_dime_cnt", int'(dcnt_w[0]), 9);
    chk("t7_busy_end", int'(busy_w[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
